// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory port between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise data beats fetch.
module memory_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE = 32'h00400000,
    parameter logic [ADDR_WIDTH-1:0] INSTRUCTION_RANGE = 32'h10010000,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_valid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_err_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_valid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_err_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  owner_q;
    logic [CW-1:0]         cnt;

    logic                  any_req;
    logic                  pick_data;
    logic                  legal;
    logic                  aligned;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_we;

    assign any_req = if_req_i | d_req_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_data;

    assign pick_data = d_req_i & (~if_req_i | ~last_data);

    // Remember which side won the most recent grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_data <= 1'b1;
        else if (state == IDLE && any_req)
            last_data <= pick_data;
    end
`else
    assign pick_data = d_req_i;
`endif

    assign win_addr    = pick_data ? d_addr_i : if_addr_i;
    assign win_we      = pick_data & d_we_i;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    // Legality of the winning request against the program/data boundary.
    always_comb begin
        aligned = (win_addr[1:0] == 2'b00);
        legal   = aligned;
        if (!pick_data)
            legal = aligned && win_addr >= ROM_BASE
                    && win_addr < INSTRUCTION_RANGE;
        else if (win_we)
            legal = aligned && win_addr >= INSTRUCTION_RANGE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; illegal requests skip the memory access.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = legal ? ACCESS : RESP;
            ACCESS:  if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winning request and capture the response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            owner_q    <= 1'b0;
            cnt        <= '0;
            if_rdata_o <= '0;
            if_err_o   <= 1'b0;
            d_rdata_o  <= '0;
            d_err_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    addr_q  <= win_addr;
                    wdata_q <= pick_data ? d_wdata_i : '0;
                    we_q    <= win_we;
                    owner_q <= pick_data;
                    cnt     <= CNT_INIT;
                    if (!legal && pick_data) begin
                        d_rdata_o <= '0;
                        d_err_o   <= 1'b1;
                    end else if (!legal) begin
                        if_rdata_o <= '0;
                        if_err_o   <= 1'b1;
                    end
                end
                ACCESS: if (cnt == '0) begin
                    if (owner_q) begin
                        d_rdata_o <= we_q ? '0 : mem_rdata_i;
                        d_err_o   <= 1'b0;
                    end else begin
                        if_rdata_o <= mem_rdata_i;
                        if_err_o   <= 1'b0;
                    end
                end else begin
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Grants, memory strobes and response pulses decoded from the state.
    always_comb begin
        if_gnt_o   = 1'b0;
        d_gnt_o    = 1'b0;
        mem_re_o   = 1'b0;
        mem_we_o   = 1'b0;
        if_valid_o = 1'b0;
        d_valid_o  = 1'b0;
        busy_o     = (state != IDLE);
        case (state)
            IDLE: if (rst_n) begin
                d_gnt_o  = pick_data;
                if_gnt_o = if_req_i & ~pick_data;
            end
            ACCESS: begin
                mem_re_o = ~we_q;
                mem_we_o = we_q & (cnt == CNT_INIT);
            end
            RESP: begin
                if_valid_o = ~owner_q;
                d_valid_o  = owner_q;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter and access sequencer in front of the memory system. It shares one memory-system port between the instruction-fetch requester and the load/store requester. It decodes each address against the program/data boundary, checks that the access is legal, and runs a fixed-latency memory access. It returns the data with a one-cycle valid pulse to the requester that won the grant.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, byte address width
- ROM_BASE, 32'h00400000, lowest legal program-memory address
- INSTRUCTION_RANGE, 32'h10010000, first data-memory address; program memory spans ROM_BASE to INSTRUCTION_RANGE-1
- MEM_LATENCY, 1, cycles the access is held on the memory port (minimum 1)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request, held until granted
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_valid_o  out  1  one-cycle pulse: if_rdata_o/if_err_o valid
- if_rdata_o  out  DATA_WIDTH  fetched instruction
- if_err_o  out  1  fetch address illegal (qualified by if_valid_o)
- d_req_i  in  1  data request, held until granted
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_WIDTH  data address
- d_wdata_i  in  DATA_WIDTH  store data
- d_gnt_o  out  1  data request accepted this cycle
- d_valid_o  out  1  one-cycle pulse: d_rdata_o/d_err_o valid
- d_rdata_o  out  DATA_WIDTH  load data (0 for stores)
- d_err_o  out  1  data access illegal (qualified by d_valid_o)
- mem_addr_o  out  ADDR_WIDTH  address to the memory system
- mem_wdata_o  out  DATA_WIDTH  write data to the memory system
- mem_re_o  out  1  read strobe
- mem_we_o  out  1  write strobe
- mem_rdata_i  in  DATA_WIDTH  memory read data
- busy_o  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is present, the winner's gnt_o is asserted combinationally.
  - On the clock edge, the winner's address, we and wdata are latched into internal registers, along with an owner bit.
  - Legal access: go to ACCESS.
  - Illegal access: go directly to RESP with err=1 and rdata=0; no memory strobe is asserted.
- Legality rules:
  - A fetch is legal iff ROM_BASE ≤ addr < INSTRUCTION_RANGE and addr[1:0]==0.
  - A load is legal iff addr[1:0]==0.
  - A store is legal iff addr ≥ INSTRUCTION_RANGE and addr[1:0]==0. Stores into program memory are errors.
- ACCESS:
  - A down-counter is loaded with MEM_LATENCY-1 on entry.
  - mem_addr_o and mem_wdata_o are driven from the latched registers for the whole state.
  - mem_re_o is high for the whole state on loads and fetches.
  - mem_we_o is high only in the first ACCESS cycle of a store.
  - When the counter reaches 0, mem_rdata_i is registered on that edge (loads/fetches only) and the FSM goes to RESP.
- RESP:
  - The owner's valid_o is high for exactly one cycle, with rdata_o and err_o.
  - The FSM returns to IDLE.
- Outside RESP, rdata_o and err_o hold their last values; valid_o is 0.
- Arbitration on simultaneous requests depends on the configuration (see below). A non-winning request stays pending and is re-evaluated in the next IDLE cycle.
- Requests arriving while busy_o=1 are ignored until IDLE; gnt_o is never asserted outside IDLE.

## Timing
- Reset values: all outputs 0, FSM in IDLE, latched registers 0, round-robin pointer = "data served last".
- Grant in cycle T, ACCESS in cycles T+1 … T+MEM_LATENCY, valid in cycle T+MEM_LATENCY+1.
- The next grant is possible in cycle T+MEM_LATENCY+2.
- Illegal access: grant in cycle T, valid with err in cycle T+1.
- Reset asserted mid-operation: outputs clear immediately (asynchronous). The transaction is dropped, and no valid pulse is produced after reset release.
- A requester deasserting req before its grant simply withdraws; no error results.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On simultaneous requests, the winner is the requester not served last.
  - The pointer updates at each grant.
  - After reset, fetch wins the first tie.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: the data requester always beats fetch.
  - No pointer register is present.

## Test plan
- Fetch 0x00400000 with MEM_LATENCY=1 and mem_rdata_i=0x20080005:
  - if_gnt_o in cycle T.
  - mem_re_o in cycle T+1 with mem_addr_o=0x00400000.
  - if_valid_o in cycle T+2 with if_rdata_o=0x20080005 and if_err_o=0.
- Store of 0xDEADBEEF to 0x10010004:
  - mem_we_o for exactly one cycle with matching address and data.
  - Then d_valid_o=1, d_err_o=0, d_rdata_o=0.
- Illegal accesses:
  - Store to 0x00400008: d_err_o=1 one cycle after grant, no strobes.
  - Fetch from 0x10010000: if_err_o=1, no strobes.
  - Load from 0x10010002: d_err_o=1.
- Both requesting continuously for 4 grants:
  - With ARB_ROUND_ROBIN_EN defined, the grant order is fetch, data, fetch, data.
  - Without it, the grant order is data ×4 and if_gnt_o stays 0.
- MEM_LATENCY=3, load from 0x10010000:
  - mem_re_o high for 3 cycles.
  - d_valid_o 4 cycles after grant, carrying the value present on mem_rdata_i in the last ACCESS cycle.
- rst_n pulsed low in the second ACCESS cycle (MEM_LATENCY=3):
  - All outputs are 0 during reset.
  - No valid pulse after release.
  - A fresh fetch to 0x00400004 afterwards completes normally.
